// File: rtl/miner_nonce_ctrl.sv
// miner_nonce_ctrl: scans a nonce range through a SHA core until a digest has enough leading zero bits
module miner_nonce_ctrl #(
  parameter int NONCE_W = 32,
  parameter int HASH_W  = 256,
  parameter int ZB_W    = 9
) (
  input  logic               clock,
  input  logic               resetb,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [NONCE_W-1:0] nonce_first_i,
  input  logic [NONCE_W-1:0] nonce_last_i,
  input  logic [ZB_W-1:0]    zero_bits_i,
  output logic               core_start_o,
  output logic [NONCE_W-1:0] core_nonce_o,
  input  logic               core_ready_i,
  input  logic               core_done_i,
  input  logic [HASH_W-1:0]  core_hash_i,
  output logic               busy_o,
  output logic               found_o,
  output logic               exhausted_o,
  output logic [NONCE_W-1:0] found_nonce_o,
  output logic [31:0]        attempts_o,
  output logic [15:0]        status_o
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, FOUND, EXHAUSTED} state_t;
  state_t state, state_nx;
  logic [NONCE_W-1:0] nonce, last, found_nonce;
  logic [ZB_W-1:0] zb;
  logic [HASH_W-1:0] hash;
  logic [31:0] attempts;
  int unsigned lz;
  logic hit, kill, launch;
  always_comb begin
    lz = HASH_W;
    for (int i = 0; i < HASH_W; i++) if (hash[i]) lz = HASH_W - 1 - i;
  end
  assign hit = (32'(zb) >= HASH_W) ? ~|hash : (lz >= 32'(zb));
  assign kill = abort_i && state != IDLE;
  assign launch = start_i && !kill && (state == IDLE || state == FOUND || state == EXHAUSTED);
  always_comb begin
    state_nx = state;
    if (kill) state_nx = IDLE;
    else if (launch) state_nx = ISSUE;
    else
      case (state)
        ISSUE:   state_nx = core_ready_i ? WAIT : ISSUE;
        WAIT:    state_nx = core_done_i ? CHECK : WAIT;
        CHECK:   state_nx = hit ? FOUND : (nonce == last) ? EXHAUSTED : ISSUE;
        default: state_nx = state;
      endcase
  end
  always_ff @(posedge clock) begin
    if (!resetb) begin
      state       <= IDLE;
      nonce       <= '0;
      last        <= '0;
      zb          <= '0;
      hash        <= '0;
      attempts    <= '0;
      found_nonce <= '0;
    end else begin
      state <= state_nx;
      if (launch) begin
        nonce       <= nonce_first_i;
        last        <= nonce_last_i;
        zb          <= zero_bits_i;
        attempts    <= '0;
        found_nonce <= '0;
      end
      if (state == WAIT && core_done_i && !kill) hash <= core_hash_i;
      if (state == CHECK && !kill) begin
        attempts <= attempts + 32'(attempts != '1);
        if (hit) found_nonce <= nonce;
        else if (nonce != last) nonce <= nonce + NONCE_W'(1);
      end
    end
  end
  assign core_start_o  = state == ISSUE;
  assign core_nonce_o  = nonce;
  assign busy_o        = state == ISSUE || state == WAIT || state == CHECK;
  assign found_o       = state == FOUND;
  assign exhausted_o   = state == EXHAUSTED;
  assign found_nonce_o = found_nonce;
  assign attempts_o    = attempts;
  assign status_o      = busy_o ? 16'hFEED : found_o ? 16'hDEAD : exhausted_o ? 16'hBEEF : 16'h0000;
endmodule

// File: tb/tb_miner_nonce_ctrl.sv
// tb_miner_nonce_ctrl: directed self-checking bench for miner_nonce_ctrl
module tb_miner_nonce_ctrl;
  logic clock = 0;
  logic resetb = 0;
  logic start_i = 0;
  logic abort_i = 0;
  logic [31:0] nonce_first_i = 0;
  logic [31:0] nonce_last_i = 0;
  logic [8:0] zero_bits_i = 0;
  logic core_start_o;
  logic [31:0] core_nonce_o;
  logic core_ready_i = 0;
  logic core_done_i = 0;
  logic [255:0] core_hash_i = 0;
  logic busy_o, found_o, exhausted_o;
  logic [31:0] found_nonce_o, attempts_o;
  logic [15:0] status_o;
  int total = 0;
  int bad = 0;
  localparam logic [255:0] ONES = '1;
  localparam logic [255:0] HIT8 = {8'h00, {248{1'b1}}};
  localparam logic [255:0] LZ255 = 256'h1;
  miner_nonce_ctrl dut (
    .clock(clock), .resetb(resetb), .start_i(start_i), .abort_i(abort_i),
    .nonce_first_i(nonce_first_i), .nonce_last_i(nonce_last_i), .zero_bits_i(zero_bits_i),
    .core_start_o(core_start_o), .core_nonce_o(core_nonce_o), .core_ready_i(core_ready_i),
    .core_done_i(core_done_i), .core_hash_i(core_hash_i), .busy_o(busy_o), .found_o(found_o),
    .exhausted_o(exhausted_o), .found_nonce_o(found_nonce_o), .attempts_o(attempts_o),
    .status_o(status_o)
  );
  always #5 clock = ~clock;
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic launch(input logic [31:0] f, input logic [31:0] l, input logic [8:0] z);
    nonce_first_i = f;
    nonce_last_i = l;
    zero_bits_i = z;
    start_i = 1;
    tick();
    start_i = 0;
  endtask
  task automatic xfer(input logic [255:0] h, output logic [31:0] n, output logic ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) if (core_start_o) ok = 1; else tick();
    n = core_nonce_o;
    if (!ok) return;
    core_ready_i = 1;
    tick();
    core_ready_i = 0;
    core_done_i = 1;
    core_hash_i = h;
    tick();
    core_done_i = 0;
    tick();
  endtask
  task automatic test_reset;
    resetb = 0;
    tick();
    tick();
    resetb = 1;
    total++; if (status_o !== 16'h0000) begin bad++; $display("FAIL reset_status got=%h want=0000", status_o); end
    total++; if ({core_start_o, busy_o, found_o, exhausted_o} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {core_start_o, busy_o, found_o, exhausted_o}); end
    total++; if (attempts_o !== 32'd0) begin bad++; $display("FAIL reset_attempts got=%h want=0", attempts_o); end
    total++; if (found_nonce_o !== 32'd0 || core_nonce_o !== 32'd0) begin bad++; $display("FAIL reset_nonces got=%h/%h want=0/0", found_nonce_o, core_nonce_o); end
  endtask
  task automatic test_found;
    logic [31:0] n;
    logic ok;
    launch(32'h10, 32'h13, 9'd8);
    total++; if (core_start_o !== 1'b1) begin bad++; $display("FAIL found_latency got=%b want=1", core_start_o); end
    for (int k = 0; k < 3; k++) begin
      total++; if (status_o !== 16'hFEED) begin bad++; $display("FAIL found_status_scan got=%h want=feed", status_o); end
      xfer(k == 2 ? HIT8 : ONES, n, ok);
      total++; if (!ok || n !== 32'h10 + 32'(k)) begin bad++; $display("FAIL found_nonce_seq got=%h ok=%b want=%h", n, ok, 32'h10 + 32'(k)); end
    end
    total++; if (found_o !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("FAIL found_flag got=%b%b want=10", found_o, busy_o); end
    total++; if (found_nonce_o !== 32'h12) begin bad++; $display("FAIL found_nonce got=%h want=12", found_nonce_o); end
    total++; if (attempts_o !== 32'd3) begin bad++; $display("FAIL found_attempts got=%0d want=3", attempts_o); end
    total++; if (status_o !== 16'hDEAD) begin bad++; $display("FAIL found_status got=%h want=dead", status_o); end
  endtask
  task automatic test_exhausted;
    logic [31:0] n;
    logic ok;
    launch(32'd5, 32'd7, 9'd8);
    for (int k = 0; k < 3; k++) begin
      total++; if (status_o !== 16'hFEED) begin bad++; $display("FAIL exh_status_scan got=%h want=feed", status_o); end
      xfer(ONES, n, ok);
      total++; if (!ok || n !== 32'd5 + 32'(k)) begin bad++; $display("FAIL exh_nonce_seq got=%h ok=%b want=%h", n, ok, 32'd5 + 32'(k)); end
    end
    total++; if (exhausted_o !== 1'b1 || found_o !== 1'b0) begin bad++; $display("FAIL exh_flag got=%b%b want=10", exhausted_o, found_o); end
    total++; if (attempts_o !== 32'd3) begin bad++; $display("FAIL exh_attempts got=%0d want=3", attempts_o); end
    total++; if (status_o !== 16'hBEEF) begin bad++; $display("FAIL exh_status got=%h want=beef", status_o); end
    total++; if (found_nonce_o !== 32'd0) begin bad++; $display("FAIL exh_found_nonce got=%h want=0", found_nonce_o); end
  endtask
  task automatic test_wrap;
    logic [31:0] n;
    logic ok;
    logic [31:0] want [4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
    launch(32'hFFFFFFFE, 32'h1, 9'd4);
    for (int k = 0; k < 4; k++) begin
      xfer(ONES, n, ok);
      total++; if (!ok || n !== want[k]) begin bad++; $display("FAIL wrap_nonce_seq got=%h ok=%b want=%h", n, ok, want[k]); end
    end
    total++; if (exhausted_o !== 1'b1 || attempts_o !== 32'd4) begin bad++; $display("FAIL wrap_end got=%b/%0d want=1/4", exhausted_o, attempts_o); end
  endtask
  task automatic test_stall;
    launch(32'h100, 32'h100, 9'd0);
    for (int k = 0; k < 5; k++) begin
      total++; if (core_start_o !== 1'b1 || core_nonce_o !== 32'h100) begin bad++; $display("FAIL stall_hold got=%b/%h want=1/100", core_start_o, core_nonce_o); end
      tick();
    end
    core_ready_i = 1;
    tick();
    core_ready_i = 1;
    for (int k = 0; k < 3; k++) begin
      total++; if (core_start_o !== 1'b0 || busy_o !== 1'b1) begin bad++; $display("FAIL stall_one_xfer got=%b/%b want=0/1", core_start_o, busy_o); end
      tick();
    end
    core_ready_i = 0;
    core_done_i = 1;
    core_hash_i = ONES;
    tick();
    core_done_i = 0;
    total++; if (busy_o !== 1'b1 || found_o !== 1'b0) begin bad++; $display("FAIL stall_check_cycle got=%b%b want=10", busy_o, found_o); end
    tick();
    total++; if (found_o !== 1'b1 || found_nonce_o !== 32'h100 || attempts_o !== 32'd1) begin bad++; $display("FAIL stall_zb0 got=%b/%h/%0d want=1/100/1", found_o, found_nonce_o, attempts_o); end
  endtask
  task automatic test_zero_bits_max;
    logic [31:0] n;
    logic ok;
    launch(32'h20, 32'h21, 9'd256);
    xfer(LZ255, n, ok);
    total++; if (!ok || found_o !== 1'b0 || busy_o !== 1'b1) begin bad++; $display("FAIL zb256_reject got=%b%b ok=%b want=01", found_o, busy_o, ok); end
    xfer(256'h0, n, ok);
    total++; if (!ok || found_o !== 1'b1 || found_nonce_o !== 32'h21 || attempts_o !== 32'd2) begin bad++; $display("FAIL zb256_accept got=%b/%h/%0d want=1/21/2", found_o, found_nonce_o, attempts_o); end
  endtask
  task automatic test_abort;
    abort_i = 1;
    start_i = 1;
    tick();
    abort_i = 0;
    start_i = 0;
    total++; if (status_o !== 16'h0000 || found_o !== 1'b0 || attempts_o !== 32'd2) begin bad++; $display("FAIL abort_over_start got=%h/%b/%0d want=0000/0/2", status_o, found_o, attempts_o); end
    launch(32'h30, 32'h40, 9'd0);
    core_ready_i = 1;
    tick();
    core_ready_i = 0;
    abort_i = 1;
    core_done_i = 1;
    core_hash_i = 256'h0;
    tick();
    abort_i = 0;
    core_done_i = 0;
    total++; if (status_o !== 16'h0000 || busy_o !== 1'b0 || core_start_o !== 1'b0) begin bad++; $display("FAIL abort_wait got=%h/%b/%b want=0000/0/0", status_o, busy_o, core_start_o); end
    tick();
    tick();
    total++; if (found_o !== 1'b0 || attempts_o !== 32'd0 || status_o !== 16'h0000) begin bad++; $display("FAIL abort_unchecked got=%b/%0d/%h want=0/0/0000", found_o, attempts_o, status_o); end
  endtask
  task automatic test_reset_mid;
    logic [31:0] n;
    logic ok;
    launch(32'h50, 32'h60, 9'd8);
    xfer(ONES, n, ok);
    core_ready_i = 1;
    tick();
    core_ready_i = 0;
    total++; if (!ok || attempts_o !== 32'd1 || busy_o !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%0d/%b ok=%b want=1/1", attempts_o, busy_o, ok); end
    resetb = 0;
    core_done_i = 1;
    core_hash_i = 256'h0;
    tick();
    resetb = 1;
    tick();
    core_done_i = 0;
    total++; if ({core_start_o, busy_o, found_o, exhausted_o} !== 4'b0 || status_o !== 16'h0000) begin bad++; $display("FAIL rstmid_flags got=%b/%h want=0000/0000", {core_start_o, busy_o, found_o, exhausted_o}, status_o); end
    total++; if (attempts_o !== 32'd0 || found_nonce_o !== 32'd0 || core_nonce_o !== 32'd0) begin bad++; $display("FAIL rstmid_regs got=%0d/%h/%h want=0/0/0", attempts_o, found_nonce_o, core_nonce_o); end
    launch(32'h77, 32'h77, 9'd0);
    total++; if (core_start_o !== 1'b1 || core_nonce_o !== 32'h77) begin bad++; $display("FAIL rstmid_restart got=%b/%h want=1/77", core_start_o, core_nonce_o); end
    xfer(ONES, n, ok);
    total++; if (!ok || found_o !== 1'b1 || found_nonce_o !== 32'h77 || attempts_o !== 32'd1) begin bad++; $display("FAIL rstmid_found got=%b/%h/%0d want=1/77/1", found_o, found_nonce_o, attempts_o); end
  endtask
  initial begin
    test_reset();
    test_found();
    test_exhausted();
    test_wrap();
    test_stall();
    test_zero_bits_max();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
